// File: rtl/read_stage_vrf_read_pipe.sv
// VRF bank read pipe: issues arbiter-granted reads, tracks tags through the bank latency, and buffers responses under a credit scheme.
// Optional macro READ_STAGE_VRF_PIPE_PERF_EN adds saturating credit/bank stall counters.
module read_stage_vrf_read_pipe #(
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_valid,
  output logic                  io_in_ready,
  input  logic [4:0]            io_in_bits_vs,
  input  logic [5:0]            io_in_bits_offset,
  input  logic [3:0]            io_in_bits_readSource,
  input  logic [2:0]            io_in_bits_instructionIndex,
  output logic                  io_vrfReadRequest_valid,
  input  logic                  io_vrfReadRequest_ready,
  output logic [10:0]           io_vrfReadRequest_bits_addr,
  input  logic [DATA_WIDTH-1:0] io_vrfReadData,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [DATA_WIDTH-1:0] io_out_bits_data,
  output logic [3:0]            io_out_bits_readSource,
  output logic [2:0]            io_out_bits_instructionIndex,
  output logic [4:0]            io_occupancy
`ifdef READ_STAGE_VRF_PIPE_PERF_EN
  ,
  output logic [15:0]           io_perf_creditStall,
  output logic [15:0]           io_perf_bankStall
`endif
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         ENTRY_W = DATA_WIDTH + 7;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [4:0]               occ_q, occ_d;
  logic                     has_credit;
  logic                     fire;
  logic                     pop;
  logic                     capture;
  logic [READ_LATENCY-1:0]  pipe_vld_q;
  logic [3:0]               pipe_src_q [READ_LATENCY];
  logic [2:0]               pipe_idx_q [READ_LATENCY];
  logic [ENTRY_W-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [4:0]               fifo_cnt_q, fifo_cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes are strict valid/ready: a transfer happens exactly on a cycle where
  // valid && ready; request ready depends on credit and bank ready, never on valid.
  assign has_credit                  = occ_q < DEPTH_C;
  assign io_vrfReadRequest_valid     = io_in_valid && has_credit;
  assign io_in_ready                 = io_vrfReadRequest_ready && has_credit;
  assign fire                        = io_in_valid && io_in_ready;
  assign io_vrfReadRequest_bits_addr = {io_in_bits_vs, io_in_bits_offset};

  assign capture      = pipe_vld_q[READ_LATENCY-1];
  assign io_out_valid = fifo_cnt_q != 5'd0;
  assign pop          = io_out_valid && io_out_ready;
  assign io_occupancy = occ_q;
  assign {io_out_bits_data, io_out_bits_readSource, io_out_bits_instructionIndex} = mem_q[rd_ptr_q];

  // Capture only moves an entry from in-flight to buffered, so it does not touch occupancy.
  always_comb begin
    occ_d = occ_q;
    case ({fire, pop})
      2'b10:   occ_d = occ_q + 5'd1;
      2'b01:   occ_d = occ_q - 5'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({capture, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 5'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 5'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_src_q[i] <= '0;
        pipe_idx_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= fire;
      pipe_src_q[0] <= io_in_bits_readSource;
      pipe_idx_q[0] <= io_in_bits_instructionIndex;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_src_q[i] <= pipe_src_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      occ_q      <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      occ_q      <= occ_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (capture) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage needs no reset: pointers and count already define what is valid.
  always_ff @(posedge clock) begin
    if (reset && capture) begin
      mem_q[wr_ptr_q] <= {io_vrfReadData, pipe_src_q[READ_LATENCY-1], pipe_idx_q[READ_LATENCY-1]};
    end
  end

`ifdef READ_STAGE_VRF_PIPE_PERF_EN
  logic [15:0] credit_stall_q, bank_stall_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      credit_stall_q <= '0;
      bank_stall_q   <= '0;
    end else begin
      if (io_in_valid && !has_credit && credit_stall_q != 16'hFFFF)
        credit_stall_q <= credit_stall_q + 16'd1;
      if (io_in_valid && has_credit && !io_vrfReadRequest_ready && bank_stall_q != 16'hFFFF)
        bank_stall_q <= bank_stall_q + 16'd1;
    end
  end

  assign io_perf_creditStall = credit_stall_q;
  assign io_perf_bankStall   = bank_stall_q;
`endif

endmodule

// File: tb/tb_read_stage_vrf_read_pipe.sv
// Bench for read_stage_vrf_read_pipe: directed scenarios plus random traffic against a queue-based response model.
module tb_read_stage_vrf_read_pipe;

  localparam int DEPTH        = 4;
  localparam int READ_LATENCY = 2;
  localparam int DATA_WIDTH   = 32;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  io_in_valid;
  logic                  io_in_ready;
  logic [4:0]            io_in_bits_vs;
  logic [5:0]            io_in_bits_offset;
  logic [3:0]            io_in_bits_readSource;
  logic [2:0]            io_in_bits_instructionIndex;
  logic                  io_vrfReadRequest_valid;
  logic                  io_vrfReadRequest_ready;
  logic [10:0]           io_vrfReadRequest_bits_addr;
  logic [DATA_WIDTH-1:0] io_vrfReadData;
  logic                  io_out_valid;
  logic                  io_out_ready;
  logic [DATA_WIDTH-1:0] io_out_bits_data;
  logic [3:0]            io_out_bits_readSource;
  logic [2:0]            io_out_bits_instructionIndex;
  logic [4:0]            io_occupancy;
`ifdef READ_STAGE_VRF_PIPE_PERF_EN
  logic [15:0]           io_perf_creditStall;
  logic [15:0]           io_perf_bankStall;
`endif

  read_stage_vrf_read_pipe #(
    .DEPTH(DEPTH), .READ_LATENCY(READ_LATENCY), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clock                       (clock),
    .reset                       (reset),
    .io_in_valid                 (io_in_valid),
    .io_in_ready                 (io_in_ready),
    .io_in_bits_vs               (io_in_bits_vs),
    .io_in_bits_offset           (io_in_bits_offset),
    .io_in_bits_readSource       (io_in_bits_readSource),
    .io_in_bits_instructionIndex (io_in_bits_instructionIndex),
    .io_vrfReadRequest_valid     (io_vrfReadRequest_valid),
    .io_vrfReadRequest_ready     (io_vrfReadRequest_ready),
    .io_vrfReadRequest_bits_addr (io_vrfReadRequest_bits_addr),
    .io_vrfReadData              (io_vrfReadData),
    .io_out_valid                (io_out_valid),
    .io_out_ready                (io_out_ready),
    .io_out_bits_data            (io_out_bits_data),
    .io_out_bits_readSource      (io_out_bits_readSource),
    .io_out_bits_instructionIndex(io_out_bits_instructionIndex),
    .io_occupancy                (io_occupancy)
`ifdef READ_STAGE_VRF_PIPE_PERF_EN
    ,
    .io_perf_creditStall         (io_perf_creditStall),
    .io_perf_bankStall           (io_perf_bankStall)
`endif
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: buffered responses {data, src, idx} and in-flight tags with due cycle
  logic [DATA_WIDTH+6:0] exp_q[$];
  logic [6:0]            fly_tag_q[$];
  int                    fly_due_q[$];
  int                    cyc = 0;
  int                    total = 0;
  int                    bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Driver: one cycle of stimulus, model checks mid-cycle, model update, returns just past the edge.
  task automatic step(input logic iv, input logic [4:0] vs, input logic [5:0] off,
                      input logic [3:0] src, input logic [2:0] idx, input logic bank_rdy,
                      input logic out_rdy, input logic [31:0] rdata, input logic rst_n);
    int occ_m;
    bit credit, fire_m, pop_m;
    @(negedge clock);
    reset                       = rst_n;
    io_in_valid                 = iv;
    io_in_bits_vs               = vs;
    io_in_bits_offset           = off;
    io_in_bits_readSource       = src;
    io_in_bits_instructionIndex = idx;
    io_vrfReadRequest_ready     = bank_rdy;
    io_out_ready                = out_rdy;
    io_vrfReadData              = rdata;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      fly_tag_q.delete();
      fly_due_q.delete();
    end else begin
      occ_m  = fly_tag_q.size() + exp_q.size();
      credit = occ_m < DEPTH;
      check_eq("occupancy", 64'(io_occupancy), 64'(occ_m));
      check_eq("in_ready", 64'(io_in_ready), 64'(bank_rdy && credit));
      check_eq("req_valid", 64'(io_vrfReadRequest_valid), 64'(iv && credit));
      if (iv && credit) check_eq("req_addr", 64'(io_vrfReadRequest_bits_addr), 64'({vs, off}));
      check_eq("out_valid", 64'(io_out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        check_eq("out_bits", 64'({io_out_bits_data, io_out_bits_readSource, io_out_bits_instructionIndex}),
                 64'(exp_q[0]));
      fire_m = iv && bank_rdy && credit;
      pop_m  = (exp_q.size() != 0) && out_rdy;
      if (pop_m) void'(exp_q.pop_front());
      if (fly_due_q.size() != 0 && fly_due_q[0] == cyc) begin
        exp_q.push_back({rdata, fly_tag_q[0]});
        void'(fly_tag_q.pop_front());
        void'(fly_due_q.pop_front());
      end
      if (fire_m) begin
        fly_tag_q.push_back({src, idx});
        fly_due_q.push_back(cyc + READ_LATENCY);
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic out_rdy);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, out_rdy, $urandom, 1'b1);
  endtask

  task automatic rand_req(input logic bank_rdy, input logic out_rdy);
    step(1'b1, 5'($urandom), 6'($urandom), 4'($urandom), 3'($urandom), bank_rdy, out_rdy, $urandom, 1'b1);
  endtask

  int max_occ;

  initial begin
    reset = 1'b0; io_in_valid = 1'b0; io_in_bits_vs = '0; io_in_bits_offset = '0;
    io_in_bits_readSource = '0; io_in_bits_instructionIndex = '0;
    io_vrfReadRequest_ready = 1'b1; io_out_ready = 1'b0; io_vrfReadData = '0;

    step(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    check_eq("reset_occ", 64'(io_occupancy), 64'd0);
    check_eq("reset_out_valid", 64'(io_out_valid), 64'd0);

    // Single read: out_valid exactly READ_LATENCY+1 cycles after fire
    step(1'b1, 5'd3, 6'd5, 4'h2, 3'd1, 1'b1, 1'b0, $urandom, 1'b1);
    check_eq("single_addr", 64'(io_vrfReadRequest_bits_addr), 64'h0C5);
    step(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, $urandom, 1'b1);
    check_eq("single_early", 64'(io_out_valid), 64'd0);
    step(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    check_eq("single_valid", 64'(io_out_valid), 64'd1);
    check_eq("single_data", 64'(io_out_bits_data), 64'hDEADBEEF);
    check_eq("single_src", 64'(io_out_bits_readSource), 64'h2);
    check_eq("single_idx", 64'(io_out_bits_instructionIndex), 64'h1);
    idle(2, 1'b1);

    // Backpressure fill
    for (int i = 0; i < DEPTH + 1; i++) rand_req(1'b1, 1'b0);
    check_eq("fill_occ", 64'(io_occupancy), 64'(DEPTH));
    check_eq("fill_in_ready", 64'(io_in_ready), 64'd0);
    check_eq("fill_req_valid", 64'(io_vrfReadRequest_valid), 64'd0);
    idle(DEPTH + READ_LATENCY + 2, 1'b1);
    check_eq("drain_occ", 64'(io_occupancy), 64'd0);
    check_eq("drain_in_ready", 64'(io_in_ready), 64'd1);

    // Bank conflict
    for (int i = 0; i < 3; i++) begin
      rand_req(1'b0, 1'b1);
      check_eq("conflict_in_ready", 64'(io_in_ready), 64'd0);
      check_eq("conflict_occ", 64'(io_occupancy), 64'd0);
    end
    rand_req(1'b1, 1'b1);
    check_eq("conflict_release_occ", 64'(io_occupancy), 64'd1);
    idle(READ_LATENCY + 3, 1'b1);

    // Streaming: full throughput, no output gaps once the first response lands
    max_occ = 0;
    for (int i = 0; i < 20; i++) begin
      rand_req(1'b1, 1'b1);
      if (int'(io_occupancy) > max_occ) max_occ = int'(io_occupancy);
      if (i >= READ_LATENCY) check_eq("stream_no_gap", 64'(io_out_valid), 64'd1);
    end
    check_eq("stream_occ_bound", 64'(max_occ <= READ_LATENCY + 1), 64'd1);
    idle(READ_LATENCY + 3, 1'b1);

    // Reset mid-flight
    rand_req(1'b1, 1'b0);
    rand_req(1'b1, 1'b0);
    step(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, $urandom, 1'b0);
    check_eq("midreset_occ", 64'(io_occupancy), 64'd0);
    check_eq("midreset_out_valid", 64'(io_out_valid), 64'd0);
    for (int i = 0; i < READ_LATENCY + 2; i++) begin
      idle(1, 1'b0);
      check_eq("midreset_no_emit", 64'(io_out_valid), 64'd0);
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 70), 5'($urandom), 6'($urandom), 4'($urandom), 3'($urandom),
           1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < 55), $urandom,
           1'($urandom_range(0, 199) != 0));
    end
    idle(DEPTH + READ_LATENCY + 2, 1'b1);

`ifdef READ_STAGE_VRF_PIPE_PERF_EN
    step(1'b0, 5'd0, 6'd0, 4'd0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) rand_req(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) rand_req(1'b1, 1'b0);
    idle(DEPTH + READ_LATENCY + 2, 1'b1);
    for (int i = 0; i < 2; i++) rand_req(1'b0, 1'b1);
    check_eq("perf_credit", 64'(io_perf_creditStall), 64'd5);
    check_eq("perf_bank", 64'(io_perf_bankStall), 64'd2);
    idle(2, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
